// File: rtl/sdram_loader_pkg.sv
// Shared types and constants for the byte-stream-to-SDRAM write stage.
package sdram_loader_pkg;

    // Issuer states: present a word, wait for acceptance, then hold req low one cycle.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    // One packed SDRAM word waiting to be written.
    typedef struct packed {
        logic [25:0] addr;
        logic [15:0] data;
        logic [1:0]  be;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    // dl_wait rises once the FIFO has this few free entries left.
    localparam int WAIT_MARGIN = 2;

    // Place a byte into the selected lane of a 16-bit little-endian word.
    function automatic logic [15:0] lane_write(input logic [15:0] word,
                                               input logic        lane,
                                               input logic [7:0]  b);
        logic [15:0] w;
        w = word;
        if (lane) begin
            w[15:8] = b;
        end else begin
            w[7:0] = b;
        end
        return w;
    endfunction

    // Byte-enable bit for a lane; lane 0 is the low byte.
    function automatic logic [1:0] lane_be(input logic lane);
        return lane ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/sdram_loader_fifo.sv
// Small synchronous FIFO with occupancy count; pushes into a full FIFO are ignored.
module sdram_loader_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 44
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/sdram_loader.sv
// Packs download bytes into 16-bit words with byte enables and writes them
// to the SDRAM controller one word at a time via a rising-edge req handshake.
module sdram_loader
    import sdram_loader_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dl_active,
    input  logic        dl_wr,
    input  logic [26:0] dl_addr,
    input  logic [7:0]  dl_data,
    output logic        dl_wait,
    output logic        dl_done,
    output logic        dl_overflow,
    output logic [23:0] words_written,
    output logic [25:0] sd_addr,
    output logic [15:0] sd_din,
    output logic [1:0]  sd_be,
    output logic        sd_rnw,
    output logic        sd_req,
    input  logic        sd_ready
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // Window edge detection
    logic        active_q;
    logic        rise;
    logic        fall;
    logic        wr_acc;

    // Packer hold register and its next state
    logic        hold_valid;
    logic [25:0] hold_addr;
    logic [15:0] hold_data;
    logic [1:0]  hold_be;
    logic        hold_valid_n;
    logic [25:0] hold_addr_n;
    logic [15:0] hold_data_n;
    logic [1:0]  hold_be_n;
    logic [15:0] merged_data;
    logic [1:0]  merged_be;

    // FIFO side
    logic        push;
    entry_t      push_entry;
    entry_t      head;
    logic        pop;
    logic [CW-1:0] fifo_count;
    logic        fifo_full;
    logic        fifo_empty;
    logic        head_avail;

    // Issuer and completion
    state_t      state;
    logic        done_pending;
    logic        done_cond;

    assign rise   = dl_active && !active_q;
    assign fall   = !dl_active && active_q;
    assign wr_acc = dl_wr && dl_active;
    assign sd_rnw = 1'b0;

    assign merged_data = lane_write(hold_data, dl_addr[0], dl_data);
    assign merged_be   = hold_be | lane_be(dl_addr[0]);

    // head_avail is a registered non-empty flag, so the issue decision never
    // depends on a word written at the immediately preceding edge.
    assign pop       = (state == S_IDLE) && head_avail && !fifo_empty;
    assign done_cond = done_pending && !hold_valid && fifo_empty && (state == S_IDLE);

    // Packer: merge, push, reload or flush the hold; at most one push per cycle.
    always_comb begin
        push         = 1'b0;
        push_entry   = '{addr: hold_addr, data: hold_data, be: hold_be};
        hold_valid_n = hold_valid;
        hold_addr_n  = hold_addr;
        hold_data_n  = hold_data;
        hold_be_n    = hold_be;
        if (wr_acc) begin
            if (hold_valid && (hold_addr == dl_addr[26:1])) begin
                if (merged_be == 2'b11) begin
                    push         = 1'b1;
                    push_entry   = '{addr: hold_addr, data: merged_data, be: 2'b11};
                    hold_valid_n = 1'b0;
                end else begin
                    hold_data_n = merged_data;
                    hold_be_n   = merged_be;
                end
            end else begin
                // A different word: the old hold (if any) leaves as-is.
                push         = hold_valid;
                hold_valid_n = 1'b1;
                hold_addr_n  = dl_addr[26:1];
                hold_data_n  = lane_write(16'h0000, dl_addr[0], dl_data);
                hold_be_n    = lane_be(dl_addr[0]);
            end
        end else if (fall && hold_valid) begin
            push         = 1'b1;
            hold_valid_n = 1'b0;
        end
    end

    // Hold register update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_valid <= 1'b0;
            hold_addr  <= '0;
            hold_data  <= '0;
            hold_be    <= '0;
        end else begin
            hold_valid <= hold_valid_n;
            hold_addr  <= hold_addr_n;
            hold_data  <= hold_data_n;
            hold_be    <= hold_be_n;
        end
    end

    sdram_loader_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (push_entry),
        .dout  (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Window tracking, back-pressure, overflow and completion flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_q     <= 1'b0;
            head_avail   <= 1'b0;
            dl_wait      <= 1'b0;
            dl_overflow  <= 1'b0;
            done_pending <= 1'b0;
            dl_done      <= 1'b0;
        end else begin
            active_q    <= dl_active;
            head_avail  <= !fifo_empty;
            dl_wait     <= (fifo_count >= CW'(FIFO_DEPTH - WAIT_MARGIN));
            dl_overflow <= (dl_overflow && !rise) || (push && fifo_full);
            dl_done     <= done_cond;
            if (rise) begin
                done_pending <= 1'b0;
            end else if (fall) begin
                done_pending <= 1'b1;
            end else if (done_cond) begin
                done_pending <= 1'b0;
            end
        end
    end

    // Issuer FSM: registered request and payload, held until the controller accepts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            sd_req        <= 1'b0;
            sd_addr       <= '0;
            sd_din        <= '0;
            sd_be         <= '0;
            words_written <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        sd_addr <= head.addr;
                        sd_din  <= head.data;
                        sd_be   <= head.be;
                        sd_req  <= 1'b1;
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (sd_ready) begin
                        sd_req        <= 1'b0;
                        words_written <= words_written + 24'd1;
                        state         <= S_GAP;
                    end
                end
                S_GAP: begin
                    state <= S_IDLE;
                end
                default: begin
                    sd_req <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
            if (rise) begin
                words_written <= '0;
            end
        end
    end

endmodule

// File: tb/tb_sdram_loader.sv
// Bench for sdram_loader: directed vector table, hand-written corner sequences
// and random byte windows scored against a word-grouping reference model.
module tb_sdram_loader;

    localparam int DEPTH = 8;

    logic        clk;
    logic        reset;
    logic        dl_active;
    logic        dl_wr;
    logic [26:0] dl_addr;
    logic [7:0]  dl_data;
    logic        dl_wait;
    logic        dl_done;
    logic        dl_overflow;
    logic [23:0] words_written;
    logic [25:0] sd_addr;
    logic [15:0] sd_din;
    logic [1:0]  sd_be;
    logic        sd_rnw;
    logic        sd_req;
    logic        sd_ready;

    sdram_loader #(.FIFO_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .dl_active     (dl_active),
        .dl_wr         (dl_wr),
        .dl_addr       (dl_addr),
        .dl_data       (dl_data),
        .dl_wait       (dl_wait),
        .dl_done       (dl_done),
        .dl_overflow   (dl_overflow),
        .words_written (words_written),
        .sd_addr       (sd_addr),
        .sd_din        (sd_din),
        .sd_be         (sd_be),
        .sd_rnw        (sd_rnw),
        .sd_req        (sd_req),
        .sd_ready      (sd_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [25:0] addr;
        logic [15:0] data;
        logic [1:0]  be;
    } wr_t;

    typedef struct {
        int               n;
        logic [2:0][26:0] a;
        logic [2:0][7:0]  d;
        int               ne;
        logic [1:0][25:0] ea;
        logic [1:0][15:0] ed;
        logic [1:0][1:0]  eb;
    } vec_t;

    int errors = 0;
    int checks = 0;

    wr_t  got_q[$];
    wr_t  exp_q[$];
    logic [26:0] win_a[$];
    logic [7:0]  win_d[$];
    vec_t vt[$];

    // controller model state
    int  rdy_delay = 0;
    bit  stall = 0;
    int  low_cnt = 100;
    bit  req_seen = 0;
    bit  ready_given = 0;
    int  wait_cnt = 0;
    wr_t cur;
    int  done_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // SDRAM controller model: latch payload on req rise, answer with a one-cycle ready.
    always @(negedge clk) begin
        if (reset) begin
            sd_ready    = 1'b0;
            req_seen    = 0;
            ready_given = 0;
            low_cnt     = 100;
        end else begin
            sd_ready = 1'b0;
            if (!sd_req) begin
                req_seen = 0;
                low_cnt++;
            end else if (!req_seen) begin
                req_seen    = 1;
                ready_given = 0;
                wait_cnt    = rdy_delay;
                cur = '{addr: sd_addr, data: sd_din, be: sd_be};
                got_q.push_back(cur);
                chk("req_low_gap", 64'(low_cnt >= 2), 64'd1);
                chk("rnw", 64'(sd_rnw), 64'd0);
                low_cnt = 0;
            end else if (!ready_given) begin
                chk("payload_stable", {sd_addr, sd_din, sd_be}, {cur.addr, cur.data, cur.be});
            end
            if (req_seen && !ready_given && !stall) begin
                if (wait_cnt == 0) begin
                    sd_ready    = 1'b1;
                    ready_given = 1;
                end else begin
                    wait_cnt--;
                end
            end
        end
        if (dl_done) done_cnt++;
    end

    // Reference: bytes group into a word while they stay on one word address;
    // a word leaves when both lanes are filled, the address changes, or the window ends.
    task automatic model_window();
        bit          have;
        logic [25:0] cw;
        logic [7:0]  lo;
        logic [7:0]  hi;
        logic [1:0]  m;
        logic [25:0] w;
        logic        ln;
        exp_q.delete();
        have = 0; cw = '0; lo = '0; hi = '0; m = '0;
        for (int i = 0; i < win_a.size(); i++) begin
            w  = win_a[i][26:1];
            ln = win_a[i][0];
            if (!(have && w == cw)) begin
                if (have) exp_q.push_back('{addr: cw, data: {hi, lo}, be: m});
                cw = w; lo = '0; hi = '0; m = '0; have = 1;
            end
            if (ln) hi = win_d[i]; else lo = win_d[i];
            m[ln] = 1'b1;
            if (m == 2'b11) begin
                exp_q.push_back('{addr: cw, data: {hi, lo}, be: m});
                have = 0;
            end
        end
        if (have) exp_q.push_back('{addr: cw, data: {hi, lo}, be: m});
    endtask

    task automatic send_byte(input logic [26:0] a, input logic [7:0] d, input bit honor);
        int t;
        if (honor) begin
            t = 0;
            while (dl_wait && t < 1000) begin
                @(negedge clk);
                t++;
            end
            chk("dl_wait_released", 64'(dl_wait), 64'd0);
        end
        dl_wr = 1'b1; dl_addr = a; dl_data = d;
        @(negedge clk);
        dl_wr = 1'b0;
    endtask

    // Drop the window, wait for dl_done and score the captured writes against exp_q.
    task automatic finish_window(input string tag);
        int t;
        int d0;
        int n;
        d0 = done_cnt;
        dl_active = 1'b0;
        t = 0;
        while (done_cnt == d0 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        repeat (5) @(negedge clk);
        chk({tag, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
        chk({tag, "_nwrites"}, 64'(got_q.size()), 64'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_addr"}, 64'(got_q[i].addr), 64'(exp_q[i].addr));
            chk({tag, "_data"}, 64'(got_q[i].data), 64'(exp_q[i].data));
            chk({tag, "_be"},   64'(got_q[i].be),   64'(exp_q[i].be));
        end
        chk({tag, "_words_written"}, 64'(words_written), 64'(exp_q.size()));
        chk({tag, "_overflow"}, 64'(dl_overflow), 64'd0);
    endtask

    task automatic run_window(input string tag, input bit honor, input int gap_max);
        got_q.delete();
        dl_active = 1'b1;
        @(negedge clk);
        for (int i = 0; i < win_a.size(); i++) begin
            if (gap_max > 0) repeat ($urandom_range(0, gap_max)) @(negedge clk);
            send_byte(win_a[i], win_d[i], honor);
        end
        finish_window(tag);
    endtask

    task automatic add_vec(input int n,
                           input logic [26:0] a0, input logic [7:0] d0,
                           input logic [26:0] a1, input logic [7:0] d1,
                           input logic [26:0] a2, input logic [7:0] d2,
                           input int ne,
                           input logic [25:0] ea0, input logic [15:0] ed0, input logic [1:0] eb0,
                           input logic [25:0] ea1, input logic [15:0] ed1, input logic [1:0] eb1);
        vec_t v;
        v.n = n;
        v.a[0] = a0; v.d[0] = d0; v.a[1] = a1; v.d[1] = d1; v.a[2] = a2; v.d[2] = d2;
        v.ne = ne;
        v.ea[0] = ea0; v.ed[0] = ed0; v.eb[0] = eb0;
        v.ea[1] = ea1; v.ed[1] = ed1; v.eb[1] = eb1;
        vt.push_back(v);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [26:0] a;
        int n;
        reset = 1'b1; dl_active = 1'b0; dl_wr = 1'b0; dl_addr = '0; dl_data = '0;
        sd_ready = 1'b0;

        // directed vectors: {bytes} -> {expected writes}
        add_vec(2, 27'h000, 8'h11, 27'h001, 8'h22, 27'h0, 8'h0,
                1, 26'h000, 16'h2211, 2'b11, 26'h0, 16'h0, 2'b00);
        add_vec(3, 27'h100, 8'hA0, 27'h101, 8'hA1, 27'h102, 8'hA2,
                2, 26'h080, 16'hA1A0, 2'b11, 26'h081, 16'h00A2, 2'b01);
        add_vec(2, 27'h010, 8'hAA, 27'h021, 8'hBB, 27'h0, 8'h0,
                2, 26'h008, 16'h00AA, 2'b01, 26'h010, 16'hBB00, 2'b10);
        add_vec(3, 27'h040, 8'h01, 27'h040, 8'h02, 27'h041, 8'h03,
                1, 26'h020, 16'h0302, 2'b11, 26'h0, 16'h0, 2'b00);
        add_vec(2, 27'h201, 8'h55, 27'h200, 8'h66, 27'h0, 8'h0,
                1, 26'h100, 16'h5566, 2'b11, 26'h0, 16'h0, 2'b00);
        add_vec(1, 27'h7FFFFFF, 8'h77, 27'h0, 8'h0, 27'h0, 8'h0,
                1, 26'h3FFFFFF, 16'h7700, 2'b10, 26'h0, 16'h0, 2'b00);

        repeat (3) @(negedge clk);
        chk("rst_sd_req", 64'(sd_req), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_sd_req_after", 64'(sd_req), 64'd0);
        chk("rst_sd_addr", 64'(sd_addr), 64'd0);
        chk("rst_sd_din", 64'(sd_din), 64'd0);
        chk("rst_sd_be", 64'(sd_be), 64'd0);
        chk("rst_dl_wait", 64'(dl_wait), 64'd0);
        chk("rst_dl_done", 64'(dl_done), 64'd0);
        chk("rst_dl_overflow", 64'(dl_overflow), 64'd0);
        chk("rst_words_written", 64'(words_written), 64'd0);

        // latency: word completed at edge N -> sd_req high after edge N+2
        rdy_delay = 0;
        got_q.delete();
        dl_active = 1'b1;
        @(negedge clk);
        send_byte(27'h000, 8'h11, 1'b1);
        send_byte(27'h001, 8'h22, 1'b1);
        chk("lat_after_n", 64'(sd_req), 64'd0);
        @(negedge clk);
        chk("lat_after_n1", 64'(sd_req), 64'd0);
        @(negedge clk);
        chk("lat_after_n2", 64'(sd_req), 64'd1);
        exp_q.delete();
        exp_q.push_back('{addr: 26'h0, data: 16'h2211, be: 2'b11});
        finish_window("latency");

        // table-driven windows
        rdy_delay = 1;
        for (int k = 0; k < vt.size(); k++) begin
            win_a.delete(); win_d.delete();
            for (int i = 0; i < vt[k].n; i++) begin
                win_a.push_back(vt[k].a[i]);
                win_d.push_back(vt[k].d[i]);
            end
            exp_q.delete();
            for (int i = 0; i < vt[k].ne; i++)
                exp_q.push_back('{addr: vt[k].ea[i], data: vt[k].ed[i], be: vt[k].eb[i]});
            run_window($sformatf("vec%0d", k), 1'b1, 0);
        end

        // random windows against the reference model
        for (int k = 0; k < 20; k++) begin
            win_a.delete(); win_d.delete();
            n = $urandom_range(1, 30);
            a = 27'($urandom);
            for (int i = 0; i < n; i++) begin
                win_a.push_back(a);
                win_d.push_back(8'($urandom));
                case ($urandom_range(0, 7))
                    0:       a = a;
                    1:       a = 27'($urandom);
                    default: a = a + 27'd1;
                endcase
            end
            rdy_delay = $urandom_range(0, 4);
            model_window();
            run_window($sformatf("rand%0d", k), 1'b1, 2);
        end

        // back-pressure: slow controller, 64 sequential bytes while honouring dl_wait
        rdy_delay = 20;
        win_a.delete(); win_d.delete();
        for (int i = 0; i < 64; i++) begin
            win_a.push_back(27'h1000 + 27'(i));
            win_d.push_back(8'(i * 7 + 3));
        end
        model_window();
        chk("bp_expected_words", 64'(exp_q.size()), 64'd32);
        run_window("backpressure", 1'b1, 0);

        // forced overflow: controller stalled, dl_wait ignored
        stall = 1;
        rdy_delay = 0;
        got_q.delete();
        dl_active = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 40; i++) send_byte(27'h2000 + 27'(i), 8'(i), 1'b0);
        chk("ovf_set", 64'(dl_overflow), 64'd1);
        chk("ovf_wait_high", 64'(dl_wait), 64'd1);
        dl_active = 1'b0;
        repeat (10) @(negedge clk);
        chk("ovf_sticky", 64'(dl_overflow), 64'd1);
        chk("ovf_req_stuck", 64'(sd_req), 64'd1);
        dl_active = 1'b1;
        @(negedge clk);
        chk("ovf_cleared_on_rise", 64'(dl_overflow), 64'd0);
        chk("ww_cleared_on_rise", 64'(words_written), 64'd0);

        // reset while a write is outstanding
        #2;
        reset = 1'b1;
        #1;
        chk("rst_mid_sd_req", 64'(sd_req), 64'd0);
        dl_active = 1'b0;
        stall = 0;
        @(negedge clk);
        reset = 1'b0;
        got_q.delete();
        n = done_cnt;
        repeat (40) @(negedge clk);
        chk("rst_mid_no_writes", 64'(got_q.size()), 64'd0);
        chk("rst_mid_no_done", 64'(done_cnt - n), 64'd0);
        chk("rst_mid_ww", 64'(words_written), 64'd0);
        chk("rst_mid_wait", 64'(dl_wait), 64'd0);
        chk("rst_mid_req", 64'(sd_req), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
